spike_counter_bank: RTL and testbench
=====================================

SPIKE_COUNTER_BANK -- requirements
Module: spike_counter_bank

Interface
REQ-001 SHALL have parameter NCH, default 8, number of spike channels (1..64).
REQ-002 SHALL have parameter CW, default 16, per-channel count width.
REQ-003 SHALL have parameter WW, default 16, window-length width in sim ticks.
REQ-004 SHALL have port neuron_clk  input  1  clock; all logic on its rising edge.
REQ-005 SHALL have port reset_global  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port sim_tick  input  1  one-cycle strobe per 1 ms simulation step, synchronous to neuron_clk.
REQ-007 SHALL have port spike_in  input  NCH  raw spike levels, one per channel.
REQ-008 SHALL have port enable  input  1  run counting windows while high.
REQ-009 SHALL have port clear  input  1  synchronous flush of live counts and window position.
REQ-010 SHALL have port window_len  input  WW  window length in sim ticks, sampled at each window start.
REQ-011 SHALL have port rd_sel  input  clog2(NCH) (min 1)  snapshot channel select.
REQ-012 SHALL have port rd_count  output  CW  selected channel's snapshot count.
REQ-013 SHALL have port rd_sat  output  1  selected channel's snapshot saturation flag.
REQ-014 SHALL have port snap_valid  output  1  one-cycle pulse when a new snapshot is latched.
REQ-015 SHALL have port snap_seq  output  16  snapshot sequence number, wraps 0xFFFF->0.

Function
REQ-016 SHALL count rising edges of each spike_in bit (registered previous value), not levels.
REQ-017 SHALL implement states IDLE, RUN, LATCH.
REQ-018 IDLE->RUN when enable=1; loads win_len_q = max(window_len,1); tick counter=0.
REQ-019 RUN: each sim_tick increments tick counter; sim_tick with tick counter == win_len_q-1 -> LATCH.
REQ-020 RUN with enable=0 -> IDLE; live counters and tick counter zeroed; snapshots retained.
REQ-021 LATCH (exactly one cycle): copy live counts/sat flags to snapshot, pulse snap_valid, increment snap_seq, zero live counters, reload win_len_q from window_len; -> RUN if enable=1 else IDLE.
REQ-022 Spike edge in LATCH cycle SHALL be counted in the new window (live counter set to 1, not 0).
REQ-023 Live counters SHALL saturate at 2^CW-1 and set per-channel sat flag; flag cleared with counter at window boundary.
REQ-024 clear=1 SHALL take priority over all state transitions: go IDLE, zero live counters, sat flags, tick counter; snapshots and snap_seq retained; no snap_valid.
REQ-025 Spike edges SHALL be counted only in RUN and LATCH; ignored in IDLE.
REQ-026 rd_count/rd_sat SHALL be registered, valid one cycle after rd_sel changes; rd_sel >= NCH returns 0.
REQ-027 rd_count SHALL reflect new snapshot one cycle after snap_valid.

Reset
REQ-028 reset_global SHALL asynchronously force IDLE, all live/snapshot counters, sat flags, edge registers, rd_count, rd_sat, snap_valid, snap_seq, tick counter to 0, win_len_q to 1.
REQ-029 Reset deassertion mid-window SHALL begin from IDLE; no partial snapshot emitted.

Structure
REQ-030 SHALL place state enum and NCH/CW/WW defaults in shared package spike_bank_pkg.
REQ-031 SHALL use one sub-module spike_chan_counter (edge detect + saturating counter + sat flag), instantiated NCH times by generate.

Verification
REQ-032 NCH=8, window_len=4, ch0 10 edges over 4 ticks -> one snap_valid, rd_sel=0 gives rd_count=10, rd_sat=0, snap_seq=1.
REQ-033 CW=4, ch3 20 edges in one window -> rd_count=15, rd_sat=1; next window 2 edges -> rd_count=2, rd_sat=0.
REQ-034 Spike edge on ch1 coincident with LATCH -> old snapshot excludes it, next snapshot counts it (1 edge total -> 1).
REQ-035 clear asserted at tick 2 of 4 -> no snap_valid; previous snapshot still readable; window restarts.
REQ-036 window_len=0 -> snapshot every sim_tick; spike_in held high 5 ticks -> exactly one count total.
REQ-037 reset_global mid-window with ch0 count 7 -> rd_count=0, snap_seq=0 immediately; no snap_valid after release until full window.

Source files
------------

// File: rtl/spike_bank_pkg.sv
// Shared definitions for the spike counter bank: default sizes, the
// window-control state encoding and a helper for select-port widths.
package spike_bank_pkg;

    localparam int NCH_DEFAULT = 8;
    localparam int CW_DEFAULT  = 16;
    localparam int WW_DEFAULT  = 16;

    // Window control: IDLE waits for enable, RUN accumulates spike edges,
    // LATCH is the single boundary cycle that publishes a snapshot.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LATCH = 2'd2
    } bank_state_t;

    // Width of a channel index; a single-channel bank still gets one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spike_chan_counter.sv
// One spike channel: rising-edge detector feeding a saturating counter
// with a sticky saturation flag. The window controller drives flush
// (zero everything), restart (window boundary) and count_en (mid-window).
module spike_chan_counter
    import spike_bank_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          neuron_clk,
    input  logic          reset_global,
    input  logic          spike,
    input  logic          count_en,
    input  logic          restart,
    input  logic          flush,
    output logic [CW-1:0] count,
    output logic          sat
);

    localparam logic [CW-1:0] COUNT_MAX = {CW{1'b1}};

    logic          prev_reg;
    logic [CW-1:0] count_reg;
    logic          sat_reg;
    logic          rise;

    // The edge register tracks the input in every state so that a level
    // already high when counting starts is not mistaken for a new spike.
    assign rise = spike & ~prev_reg;

    // Previous-sample register for edge detection.
    always_ff @(posedge neuron_clk or posedge reset_global) begin
        if (reset_global) begin
            prev_reg <= 1'b0;
        end else begin
            prev_reg <= spike;
        end
    end

    // Live count: flush wins, a boundary restarts at 0 or 1 (an edge in the
    // boundary cycle belongs to the new window), otherwise count and clamp.
    always_ff @(posedge neuron_clk or posedge reset_global) begin
        if (reset_global) begin
            count_reg <= '0;
            sat_reg   <= 1'b0;
        end else if (flush) begin
            count_reg <= '0;
            sat_reg   <= 1'b0;
        end else if (restart) begin
            count_reg <= CW'(rise);
            sat_reg   <= 1'b0;
        end else if (count_en && rise) begin
            if (count_reg == COUNT_MAX) begin
                sat_reg <= 1'b1;
            end else begin
                count_reg <= count_reg + CW'(1);
            end
        end
    end

    assign count = count_reg;
    assign sat   = sat_reg;

endmodule

// File: rtl/spike_counter_bank.sv
// Bank of per-channel spike counters that accumulate over windows of
// sim_tick strobes and publish a snapshot of all channels at each window
// boundary. Snapshots are read one channel at a time through rd_sel.
module spike_counter_bank
    import spike_bank_pkg::*;
#(
    parameter int  NCH = NCH_DEFAULT,
    parameter int  CW  = CW_DEFAULT,
    parameter int  WW  = WW_DEFAULT,
    localparam int SW  = sel_width(NCH)
) (
    input  logic           neuron_clk,
    input  logic           reset_global,
    input  logic           sim_tick,
    input  logic [NCH-1:0] spike_in,
    input  logic           enable,
    input  logic           clear,
    input  logic [WW-1:0]  window_len,
    input  logic [SW-1:0]  rd_sel,
    output logic [CW-1:0]  rd_count,
    output logic           rd_sat,
    output logic           snap_valid,
    output logic [15:0]    snap_seq
);

    // Snapshot storage covers every rd_sel code; codes past NCH are
    // permanently zero so out-of-range reads need no compare.
    localparam int            SNAP_N  = 2 ** SW;
    localparam logic [WW-1:0] WIN_ONE = WW'(1);

    bank_state_t   state_reg, state_next;
    logic [WW-1:0] tick_reg, tick_next;
    logic [WW-1:0] win_len_reg, win_len_next;
    logic [WW-1:0] win_len_eff;

    logic          live_flush;
    logic          live_restart;
    logic          live_count_en;
    logic          do_latch;

    logic [CW-1:0] live_count [NCH];
    logic          live_sat   [NCH];
    logic [CW-1:0] snap_count [SNAP_N];
    logic          snap_sat   [SNAP_N];

    logic [CW-1:0] rd_count_reg;
    logic          rd_sat_reg;
    logic          snap_valid_reg;
    logic [15:0]   snap_seq_reg;

    // A zero window length would never reach its last tick; treat it as 1.
    assign win_len_eff = (window_len == '0) ? WIN_ONE : window_len;

    // Window-control state, tick position and latched window length.
    always_ff @(posedge neuron_clk or posedge reset_global) begin
        if (reset_global) begin
            state_reg   <= ST_IDLE;
            tick_reg    <= '0;
            win_len_reg <= WIN_ONE;
        end else begin
            state_reg   <= state_next;
            tick_reg    <= tick_next;
            win_len_reg <= win_len_next;
        end
    end

    // Next state plus per-channel control strobes; clear overrides everything.
    always_comb begin
        state_next    = state_reg;
        tick_next     = tick_reg;
        win_len_next  = win_len_reg;
        live_flush    = 1'b0;
        live_restart  = 1'b0;
        live_count_en = 1'b0;
        do_latch      = 1'b0;

        if (clear) begin
            state_next = ST_IDLE;
            tick_next  = '0;
            live_flush = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (enable) begin
                        state_next   = ST_RUN;
                        win_len_next = win_len_eff;
                        tick_next    = '0;
                    end
                end
                ST_RUN: begin
                    live_count_en = 1'b1;
                    if (!enable) begin
                        state_next = ST_IDLE;
                        tick_next  = '0;
                        live_flush = 1'b1;
                    end else if (sim_tick) begin
                        if (tick_reg == win_len_reg - WIN_ONE) begin
                            state_next = ST_LATCH;
                            tick_next  = '0;
                        end else begin
                            tick_next = tick_reg + WIN_ONE;
                        end
                    end
                end
                ST_LATCH: begin
                    do_latch     = 1'b1;
                    live_restart = 1'b1;
                    tick_next    = '0;
                    win_len_next = win_len_eff;
                    if (enable) begin
                        state_next = ST_RUN;
                    end else begin
                        // Leaving for IDLE: do not carry a boundary edge
                        // into a window that has not started yet.
                        state_next = ST_IDLE;
                        live_flush = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    tick_next  = '0;
                    live_flush = 1'b1;
                end
            endcase
        end
    end

    genvar gi;

    // One counter per channel.
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            spike_chan_counter #(
                .CW(CW)
            ) u_chan (
                .neuron_clk  (neuron_clk),
                .reset_global(reset_global),
                .spike       (spike_in[gi]),
                .count_en    (live_count_en),
                .restart     (live_restart),
                .flush       (live_flush),
                .count       (live_count[gi]),
                .sat         (live_sat[gi])
            );
        end
    endgenerate

    // Snapshot registers; entries beyond the last channel stay zero.
    generate
        for (gi = 0; gi < SNAP_N; gi++) begin : g_snap
            if (gi < NCH) begin : g_real
                // Capture the finished window's count at the boundary cycle.
                always_ff @(posedge neuron_clk or posedge reset_global) begin
                    if (reset_global) begin
                        snap_count[gi] <= '0;
                        snap_sat[gi]   <= 1'b0;
                    end else if (do_latch) begin
                        snap_count[gi] <= live_count[gi];
                        snap_sat[gi]   <= live_sat[gi];
                    end
                end
            end else begin : g_pad
                // Unused select codes read back as zero.
                always_ff @(posedge neuron_clk or posedge reset_global) begin
                    if (reset_global) begin
                        snap_count[gi] <= '0;
                        snap_sat[gi]   <= 1'b0;
                    end else begin
                        snap_count[gi] <= '0;
                        snap_sat[gi]   <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    // snap_valid rises together with the new snapshot contents, so the
    // registered read port shows the new value one cycle after the pulse.
    always_ff @(posedge neuron_clk or posedge reset_global) begin
        if (reset_global) begin
            snap_valid_reg <= 1'b0;
            snap_seq_reg   <= '0;
        end else begin
            snap_valid_reg <= do_latch;
            snap_seq_reg   <= snap_seq_reg + 16'(do_latch);
        end
    end

    // Registered snapshot read port.
    always_ff @(posedge neuron_clk or posedge reset_global) begin
        if (reset_global) begin
            rd_count_reg <= '0;
            rd_sat_reg   <= 1'b0;
        end else begin
            rd_count_reg <= snap_count[rd_sel];
            rd_sat_reg   <= snap_sat[rd_sel];
        end
    end

    assign rd_count   = rd_count_reg;
    assign rd_sat     = rd_sat_reg;
    assign snap_valid = snap_valid_reg;
    assign snap_seq   = snap_seq_reg;

endmodule

// File: tb/tb_spike_counter_bank.sv
// Directed bench for spike_counter_bank with 8 channels and 4-bit counts.
module tb_spike_counter_bank;

    logic        clk;
    logic        reset_global;
    logic        sim_tick;
    logic [7:0]  spike_in;
    logic        enable;
    logic        clear;
    logic [15:0] window_len;
    logic [2:0]  rd_sel;
    logic [3:0]  rd_count;
    logic        rd_sat;
    logic        snap_valid;
    logic [15:0] snap_seq;

    int checks = 0;
    int fails  = 0;
    int snap_pulses = 0;

    spike_counter_bank #(
        .NCH(8),
        .CW (4),
        .WW (16)
    ) dut (
        .neuron_clk  (clk),
        .reset_global(reset_global),
        .sim_tick    (sim_tick),
        .spike_in    (spike_in),
        .enable      (enable),
        .clear       (clear),
        .window_len  (window_len),
        .rd_sel      (rd_sel),
        .rd_count    (rd_count),
        .rd_sat      (rd_sat),
        .snap_valid  (snap_valid),
        .snap_seq    (snap_seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (snap_valid === 1'b1) snap_pulses++;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_tick();
        sim_tick = 1'b1;
        cyc(1);
        sim_tick = 1'b0;
        cyc(2);
    endtask

    task automatic ticks(input int n);
        repeat (n) pulse_tick();
    endtask

    task automatic spike_edges(input int ch, input int n);
        repeat (n) begin
            spike_in[ch] = 1'b1;
            cyc(1);
            spike_in[ch] = 1'b0;
            cyc(1);
        end
    endtask

    task automatic restart_window();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset();
        reset_global = 1'b1;
        cyc(3);
        checks++; if (rd_count !== 4'd0)  begin fails++; $display("FAIL reset_rd_count: got %0d expected 0", rd_count); end
        checks++; if (rd_sat !== 1'b0)    begin fails++; $display("FAIL reset_rd_sat: got %0b expected 0", rd_sat); end
        checks++; if (snap_valid !== 1'b0) begin fails++; $display("FAIL reset_snap_valid: got %0b expected 0", snap_valid); end
        checks++; if (snap_seq !== 16'd0) begin fails++; $display("FAIL reset_snap_seq: got %0d expected 0", snap_seq); end
        reset_global = 1'b0;
        cyc(2);
        $display("test_reset done");
    endtask

    task automatic test_basic_window();
        int grp [4] = '{3, 3, 2, 2};
        int p0;
        window_len = 16'd4;
        enable = 1'b1;
        cyc(1);
        p0 = snap_pulses;
        for (int i = 0; i < 4; i++) begin
            spike_edges(0, grp[i]);
            pulse_tick();
        end
        cyc(2);
        rd_sel = 3'd0;
        cyc(2);
        checks++; if (snap_pulses - p0 !== 1) begin fails++; $display("FAIL basic_snap_pulses: got %0d expected 1", snap_pulses - p0); end
        checks++; if (snap_seq !== 16'd1)    begin fails++; $display("FAIL basic_snap_seq: got %0d expected 1", snap_seq); end
        checks++; if (rd_count !== 4'd10)    begin fails++; $display("FAIL basic_ch0_count: got %0d expected 10", rd_count); end
        checks++; if (rd_sat !== 1'b0)       begin fails++; $display("FAIL basic_ch0_sat: got %0b expected 0", rd_sat); end
        rd_sel = 3'd5;
        cyc(2);
        checks++; if (rd_count !== 4'd0)     begin fails++; $display("FAIL basic_ch5_count: got %0d expected 0", rd_count); end
        $display("test_basic_window done: ch0=%0d seq=%0d", 10, snap_seq);
    endtask

    task automatic test_saturation();
        restart_window();
        spike_edges(3, 20);
        ticks(4);
        cyc(2);
        rd_sel = 3'd3;
        cyc(2);
        checks++; if (rd_count !== 4'd15) begin fails++; $display("FAIL sat_count: got %0d expected 15", rd_count); end
        checks++; if (rd_sat !== 1'b1)    begin fails++; $display("FAIL sat_flag: got %0b expected 1", rd_sat); end
        checks++; if (snap_seq !== 16'd2) begin fails++; $display("FAIL sat_seq: got %0d expected 2", snap_seq); end
        spike_edges(3, 2);
        ticks(4);
        cyc(3);
        checks++; if (rd_count !== 4'd2)  begin fails++; $display("FAIL sat_next_count: got %0d expected 2", rd_count); end
        checks++; if (rd_sat !== 1'b0)    begin fails++; $display("FAIL sat_next_flag: got %0b expected 0", rd_sat); end
        checks++; if (snap_seq !== 16'd3) begin fails++; $display("FAIL sat_next_seq: got %0d expected 3", snap_seq); end
        $display("test_saturation done");
    endtask

    task automatic test_latch_edge();
        restart_window();
        ticks(3);
        sim_tick = 1'b1;
        cyc(1);
        sim_tick = 1'b0;
        spike_in[1] = 1'b1;
        cyc(1);
        spike_in[1] = 1'b0;
        cyc(2);
        rd_sel = 3'd1;
        cyc(2);
        checks++; if (rd_count !== 4'd0)  begin fails++; $display("FAIL latch_old_count: got %0d expected 0", rd_count); end
        checks++; if (snap_seq !== 16'd4) begin fails++; $display("FAIL latch_old_seq: got %0d expected 4", snap_seq); end
        ticks(4);
        cyc(3);
        checks++; if (rd_count !== 4'd1)  begin fails++; $display("FAIL latch_new_count: got %0d expected 1", rd_count); end
        checks++; if (snap_seq !== 16'd5) begin fails++; $display("FAIL latch_new_seq: got %0d expected 5", snap_seq); end
        $display("test_latch_edge done");
    endtask

    task automatic test_clear();
        int p0;
        spike_edges(1, 3);
        ticks(2);
        p0 = snap_pulses;
        restart_window();
        ticks(2);
        cyc(3);
        checks++; if (snap_pulses !== p0) begin fails++; $display("FAIL clear_no_snap: got %0d pulses expected %0d", snap_pulses, p0); end
        checks++; if (rd_count !== 4'd1)  begin fails++; $display("FAIL clear_keep_count: got %0d expected 1", rd_count); end
        checks++; if (snap_seq !== 16'd5) begin fails++; $display("FAIL clear_keep_seq: got %0d expected 5", snap_seq); end
        ticks(2);
        cyc(3);
        checks++; if (snap_pulses !== p0 + 1) begin fails++; $display("FAIL clear_restart_snap: got %0d pulses expected %0d", snap_pulses, p0 + 1); end
        checks++; if (rd_count !== 4'd0)  begin fails++; $display("FAIL clear_restart_count: got %0d expected 0", rd_count); end
        checks++; if (snap_seq !== 16'd6) begin fails++; $display("FAIL clear_restart_seq: got %0d expected 6", snap_seq); end
        $display("test_clear done");
    endtask

    task automatic test_zero_window();
        int p0;
        int sum;
        window_len = 16'd0;
        restart_window();
        rd_sel = 3'd2;
        p0 = snap_pulses;
        sum = 0;
        spike_in[2] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pulse_tick();
            cyc(1);
            sum += int'(rd_count);
            $display("zero_window tick %0d: ch2 snapshot %0d", i, rd_count);
        end
        spike_in[2] = 1'b0;
        checks++; if (sum !== 1) begin fails++; $display("FAIL zero_win_sum: got %0d expected 1", sum); end
        checks++; if (snap_pulses - p0 !== 5) begin fails++; $display("FAIL zero_win_pulses: got %0d expected 5", snap_pulses - p0); end
        checks++; if (snap_seq !== 16'd11) begin fails++; $display("FAIL zero_win_seq: got %0d expected 11", snap_seq); end
        window_len = 16'd4;
    endtask

    task automatic test_reset_mid_window();
        int p0;
        restart_window();
        rd_sel = 3'd0;
        spike_edges(0, 7);
        ticks(4);
        cyc(3);
        checks++; if (rd_count !== 4'd7) begin fails++; $display("FAIL rstmid_pre_count: got %0d expected 7", rd_count); end
        spike_edges(0, 7);
        ticks(2);
        reset_global = 1'b1;
        #2;
        checks++; if (rd_count !== 4'd0)   begin fails++; $display("FAIL rstmid_rd_count: got %0d expected 0", rd_count); end
        checks++; if (snap_seq !== 16'd0)  begin fails++; $display("FAIL rstmid_snap_seq: got %0d expected 0", snap_seq); end
        checks++; if (snap_valid !== 1'b0) begin fails++; $display("FAIL rstmid_snap_valid: got %0b expected 0", snap_valid); end
        cyc(1);
        reset_global = 1'b0;
        p0 = snap_pulses;
        cyc(1);
        ticks(3);
        cyc(2);
        checks++; if (snap_pulses !== p0) begin fails++; $display("FAIL rstmid_partial: got %0d pulses expected %0d", snap_pulses, p0); end
        ticks(1);
        cyc(3);
        checks++; if (snap_pulses !== p0 + 1) begin fails++; $display("FAIL rstmid_full: got %0d pulses expected %0d", snap_pulses, p0 + 1); end
        checks++; if (snap_seq !== 16'd1) begin fails++; $display("FAIL rstmid_seq: got %0d expected 1", snap_seq); end
        checks++; if (rd_count !== 4'd0)  begin fails++; $display("FAIL rstmid_count: got %0d expected 0", rd_count); end
        $display("test_reset_mid_window done");
    endtask

    initial begin
        reset_global = 1'b1;
        sim_tick     = 1'b0;
        spike_in     = '0;
        enable       = 1'b0;
        clear        = 1'b0;
        window_len   = 16'd4;
        rd_sel       = '0;

        test_reset();
        test_basic_window();
        test_saturation();
        test_latch_edge();
        test_clear();
        test_zero_window();
        test_reset_mid_window();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
